// File: rtl/column_hamming_arb.sv
// Round-robin arbiter that shares one column Hamming decoder among NREQ requesters and
// buffers the corrected column in a one-entry valid/ready output stage.

module column_hamming_dec (
  input  logic [9:0] code,
  output logic [5:0] data,
  output logic       syn_err
);
  logic [5:0] d;
  logic [3:0] p;
  logic [3:0] syn;
  logic [5:0] flip;

  assign d = code[5:0];
  assign p = code[9:6];

  // Classic Hamming positions: p0=1 p1=2 d0=3 p2=4 d1=5 d2=6 d3=7 p3=8 d4=9 d5=10.
  assign syn[0] = p[0] ^ d[0] ^ d[1] ^ d[3] ^ d[4];
  assign syn[1] = p[1] ^ d[0] ^ d[2] ^ d[3] ^ d[5];
  assign syn[2] = p[2] ^ d[1] ^ d[2] ^ d[3];
  assign syn[3] = p[3] ^ d[4] ^ d[5];

  always_comb begin
    flip = '0;
    case (syn)
      4'd3:    flip = 6'b000001;
      4'd5:    flip = 6'b000010;
      4'd6:    flip = 6'b000100;
      4'd7:    flip = 6'b001000;
      4'd9:    flip = 6'b010000;
      4'd10:   flip = 6'b100000;
      default: flip = '0;
    endcase
  end

  assign data    = d ^ flip;
  assign syn_err = (syn != 4'd0);
endmodule

module column_hamming_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [10*NREQ-1:0]   req_word,
  output logic [NREQ-1:0]      gnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_col,
  output logic [2:0]           out_src,
  output logic                 out_syn_err,
  output logic [CNT_W-1:0]     err_count,
  input  logic                 err_clr
);
  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [5:0]       col_q;
  logic [2:0]       src_q;
  logic             syn_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             can_accept;
  logic             grant;
  logic             found;
  logic [2:0]       gnt_idx;
  logic [7:0]       req_ext;
  logic [79:0]      word_ext;
  logic [9:0]       gnt_word;
  logic [5:0]       dec_col;
  logic             dec_err;
  logic [7:0]       gnt_ext;

  // Zero-extend to the 8-requester maximum so indexing needs no parameter-dependent widths.
  assign req_ext  = 8'(req);
  assign word_ext = 80'(req_word);

  // A new word may enter only if the output slot is empty or being drained this cycle.
  assign can_accept = (state_q == StEmpty) || out_ready;

  always_comb begin
    logic [3:0] cand;
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr_q} + 4'(off);
      if (cand >= 4'(NREQ)) begin
        cand = cand - 4'(NREQ);
      end
      if (!found && req_ext[cand[2:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[2:0];
      end
    end
  end

  assign grant    = found && can_accept;
  assign gnt_word = word_ext[gnt_idx*10 +: 10];

  column_hamming_dec u_dec (
    .code    (gnt_word),
    .data    (dec_col),
    .syn_err (dec_err)
  );

  // Gated by reset_n so no grant is shown for a word the held-in-reset register cannot take.
  assign gnt_ext = (grant && reset_n) ? (8'd1 << gnt_idx) : 8'd0;
  assign gnt     = gnt_ext[NREQ-1:0];

  always_comb begin
    logic [3:0] nxt;
    nxt   = {1'b0, gnt_idx} + 4'd1;
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (nxt == 4'(NREQ)) ? 3'd0 : nxt[2:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (grant) state_d = StFull;
      StFull:  if (out_ready && !grant) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (grant && dec_err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      col_q   <= '0;
      src_q   <= '0;
      syn_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        col_q <= dec_col;
        src_q <= gnt_idx;
        syn_q <= dec_err;
      end
    end
  end

  assign out_valid   = (state_q == StFull);
  assign out_col     = col_q;
  assign out_src     = src_q;
  assign out_syn_err = syn_q;
  assign err_count   = cnt_q;
endmodule

// File: tb/tb_column_hamming_arb.sv
// Self-checking bench for column_hamming_arb: directed scenarios plus a randomized run
// compared against a position-based Hamming and round-robin reference model.

module tb_column_hamming_arb;
  localparam int NREQ    = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [10*NREQ-1:0] req_word;
  logic [NREQ-1:0]   gnt;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_col;
  logic [2:0]        out_src;
  logic              out_syn_err;
  logic [CNT_W-1:0]  err_count;
  logic              err_clr;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit        m_full;
  logic [5:0] m_col;
  int        m_src;
  bit        m_syn;
  int        m_cnt;
  int        m_ptr;
  int        m_gidx;
  logic [NREQ-1:0] m_gnt;

  always #5 clk = ~clk;

  column_hamming_arb #(
    .NREQ  (NREQ),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_word    (req_word),
    .gnt         (gnt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_col     (out_col),
    .out_src     (out_src),
    .out_syn_err (out_syn_err),
    .err_count   (err_count),
    .err_clr     (err_clr)
  );

  // Lay the word out on Hamming positions 1..10, XOR the indices of set bits, flip that position.
  function automatic void model_decode(input logic [9:0] w, output logic [5:0] col,
                                       output bit err);
    logic [10:0] pos;
    int s;
    pos = '0;
    pos[1] = w[6]; pos[2] = w[7]; pos[3] = w[0]; pos[4] = w[8]; pos[5] = w[1];
    pos[6] = w[2]; pos[7] = w[3]; pos[8] = w[9]; pos[9] = w[4]; pos[10] = w[5];
    s = 0;
    for (int j = 1; j <= 10; j++) if (pos[j]) s = s ^ j;
    if (s >= 1 && s <= 10) pos[s] = ~pos[s];
    col = {pos[10], pos[9], pos[7], pos[6], pos[5], pos[3]};
    err = (s != 0);
  endfunction

  function automatic void model_reset();
    m_full = 0; m_col = '0; m_src = 0; m_syn = 0; m_cnt = 0; m_ptr = 0;
    m_gidx = -1; m_gnt = '0;
  endfunction

  function automatic void model_comb();
    m_gidx = -1;
    m_gnt  = '0;
    if (!m_full || out_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (req[i] && m_gidx < 0) m_gidx = i;
      end
    end
    if (m_gidx >= 0) m_gnt[m_gidx] = 1'b1;
  endfunction

  function automatic void model_clock();
    logic [5:0] col;
    bit err;
    err = 0;
    col = '0;
    if (m_gidx >= 0) begin
      model_decode(req_word[m_gidx*10 +: 10], col, err);
      m_full = 1; m_col = col; m_src = m_gidx; m_syn = err;
      m_ptr = (m_gidx + 1) % NREQ;
    end else if (m_full && out_ready) begin
      m_full = 0;
    end
    if (err_clr) m_cnt = 0;
    else if (m_gidx >= 0 && err && m_cnt < CNT_MAX) m_cnt++;
  endfunction

  task automatic apply(input logic [NREQ-1:0] r, input logic [10*NREQ-1:0] w,
                       input logic rdy, input logic clr);
    @(negedge clk);
    req = r; req_word = w; out_ready = rdy; err_clr = clr;
    #1;
    model_comb();
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req = '0; out_ready = 1'b1; err_clr = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; req_word = '0; out_ready = 1'b1; err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if ({gnt, out_valid, out_col, out_src, out_syn_err, err_count} !== '0) begin
      $display("FAIL reset_state: got gnt=%b v=%b col=%h src=%0d syn=%b cnt=%0d want all 0",
               gnt, out_valid, out_col, out_src, out_syn_err, err_count);
    end else n_pass++;
    reset_n = 1'b1;
    apply('0, '0, 1'b1, 1'b0);
    n_total++;
    if ({gnt, out_valid, err_count} !== '0) begin
      $display("FAIL idle_after_reset: got gnt=%b v=%b cnt=%0d want 0", gnt, out_valid,
               err_count);
    end else n_pass++;
    advance();
  endtask

  task automatic test_basic();
    apply(4'b0100, {10'h0, 10'h315, 20'h0}, 1'b1, 1'b0);
    n_total++;
    if (gnt !== 4'b0100) $display("FAIL basic_gnt: got %b want 0100", gnt);
    else n_pass++;
    advance();
    apply('0, '0, 1'b1, 1'b0);
    n_total++;
    if ({gnt, out_valid, out_col, out_src, out_syn_err, err_count} !==
        {4'b0, 1'b1, 6'h15, 3'd2, 1'b0, 2'd0}) begin
      $display("FAIL basic_out: got gnt=%b v=%b col=%h src=%0d syn=%b cnt=%0d want 0 1 15 2 0 0",
               gnt, out_valid, out_col, out_src, out_syn_err, err_count);
    end else n_pass++;
    advance();
  endtask

  task automatic test_correction();
    logic [9:0] words [3];
    logic [5:0] cols [3];
    words[0] = 10'h305; words[1] = 10'h001; words[2] = 10'h040;
    cols[0]  = 6'h15;   cols[1]  = 6'h00;   cols[2]  = 6'h00;
    for (int k = 0; k < 3; k++) begin
      apply(4'b1000, {words[k], 30'h0}, 1'b1, 1'b0);
      n_total++;
      if (gnt !== 4'b1000) $display("FAIL corr_gnt%0d: got %b want 1000", k, gnt);
      else n_pass++;
      advance();
      apply('0, '0, 1'b1, 1'b0);
      n_total++;
      if ({out_valid, out_col, out_src, out_syn_err, err_count} !==
          {1'b1, cols[k], 3'd3, 1'b1, 2'(k + 1)}) begin
        $display("FAIL corr_out%0d: got v=%b col=%h src=%0d syn=%b cnt=%0d want 1 %h 3 1 %0d",
                 k, out_valid, out_col, out_src, out_syn_err, err_count, cols[k], k + 1);
      end else n_pass++;
      advance();
    end
  endtask

  task automatic test_fairness();
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      apply(4'b1111, {$urandom, $urandom}, 1'b1, 1'b0);
      n_total++;
      if (gnt !== 4'(1 << (k % 4))) $display("FAIL fair_gnt%0d: got %b want %b", k, gnt,
                                             4'(1 << (k % 4)));
      else n_pass++;
      if (k > 0) begin
        n_total++;
        if ({out_valid, out_src} !== {1'b1, 3'((k - 1) % 4)}) begin
          $display("FAIL fair_src%0d: got v=%b src=%0d want 1 %0d", k, out_valid, out_src,
                   (k - 1) % 4);
        end else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] w;
    logic [5:0] col;
    bit err;
    w = {$urandom, $urandom};
    for (int k = 0; k < 3; k++) begin
      apply(4'b0010, w, 1'b0, 1'b0);
      n_total++;
      if ({gnt, out_valid, out_col, out_src} !== {4'b0, 1'b1, m_col, 3'(m_src)}) begin
        $display("FAIL bp_hold%0d: got gnt=%b v=%b col=%h src=%0d want 0 1 %h %0d", k, gnt,
                 out_valid, out_col, out_src, m_col, m_src);
      end else n_pass++;
      advance();
    end
    apply(4'b0010, w, 1'b1, 1'b0);
    n_total++;
    if (gnt !== 4'b0010) $display("FAIL bp_release_gnt: got %b want 0010", gnt);
    else n_pass++;
    advance();
    model_decode(w[19:10], col, err);
    apply('0, '0, 1'b1, 1'b0);
    n_total++;
    if ({out_valid, out_col, out_src, out_syn_err} !== {1'b1, col, 3'd1, err}) begin
      $display("FAIL bp_new_data: got v=%b col=%h src=%0d syn=%b want 1 %h 1 %b", out_valid,
               out_col, out_src, out_syn_err, col, err);
    end else n_pass++;
    advance();
  endtask

  task automatic test_counter();
    int exp_cnt [7];
    logic [9:0] w;
    logic [5:0] col;
    bit err;
    exp_cnt = '{0, 1, 2, 3, 3, 3, 0};
    apply('0, '0, 1'b1, 1'b1);
    advance();
    for (int k = 0; k < 7; k++) begin
      do begin
        w = 10'($urandom);
        model_decode(w, col, err);
      end while (!err);
      apply((k < 6) ? 4'b0001 : 4'b0000, {30'h0, w}, 1'b1, (k == 5));
      n_total++;
      if (err_count !== 2'(exp_cnt[k])) begin
        $display("FAIL cnt_sat%0d: got %0d want %0d", k, err_count, exp_cnt[k]);
      end else n_pass++;
      advance();
    end
  endtask

  task automatic test_async_reset();
    apply(4'b0100, {$urandom, $urandom}, 1'b1, 1'b0);
    advance();
    apply(4'b0010, {$urandom, $urandom}, 1'b0, 1'b0);
    #2;
    req = '0;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({gnt, out_valid, out_col, out_src, out_syn_err, err_count} !== '0) begin
      $display("FAIL areset_now: got gnt=%b v=%b col=%h src=%0d cnt=%0d want all 0", gnt,
               out_valid, out_col, out_src, err_count);
    end else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    apply(4'b1111, {$urandom, $urandom}, 1'b1, 1'b0);
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL areset_ptr0: got %b want 0001", gnt);
    else n_pass++;
    advance();
  endtask

  task automatic test_random();
    logic [NREQ-1:0]   pend;
    logic [10*NREQ-1:0] words;
    int g;
    pend  = '0;
    words = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(1) == 1) begin
          pend[i] = 1'b1;
          words[i*10 +: 10] = 10'($urandom);
        end
      end
      apply(pend, words, ($urandom_range(3) != 0), ($urandom_range(15) == 0));
      n_total++;
      if ({gnt, out_valid, (m_full ? {out_col, out_src, out_syn_err} : 10'b0), err_count} !==
          {m_gnt, m_full, (m_full ? {m_col, 3'(m_src), m_syn} : 10'b0), 2'(m_cnt)}) begin
        $display("FAIL rand%0d: got gnt=%b v=%b col=%h src=%0d syn=%b cnt=%0d want %b %b %h %0d %b %0d",
                 c, gnt, out_valid, out_col, out_src, out_syn_err, err_count, m_gnt, m_full,
                 m_col, m_src, m_syn, m_cnt);
      end else n_pass++;
      g = m_gidx;
      advance();
      if (g >= 0) pend[g] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_correction();
    test_fairness();
    test_backpressure();
    test_counter();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/column_hamming_arb.md
# column_hamming_arb

Round-robin arbiter and sequencer sharing one column address Hamming decoder among NREQ end-of-column requesters. Each requester presents a 10-bit Hamming-coded column word. The block grants one requester per cycle and decodes the word through a single shared column_hamming_dec instance (10-bit in, 6-bit corrected out). It then holds the result in a one-entry output register with a valid/ready handshake toward the readout FIFO and keeps a saturating syndrome-error count.

## Interface
Parameters:
- NREQ, 4, number of requesters; legal 2..8
- CNT_W, 8, width of error counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  NREQ  request per requester; held high with stable word until granted
- req_word  in  10*NREQ  coded word, requester i on bits [10i+9:10i]; bits 5:0 data, 9:6 parity
- gnt  out  NREQ  one-hot, one-cycle pulse; word of that requester captured this edge
- out_valid  out  1  output register holds a decoded result
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_col  out  6  corrected column address
- out_src  out  3  index of granted requester
- out_syn_err  out  1  syndrome was nonzero (corrected single error, or parity-bit error)
- err_count  out  CNT_W  saturating count of accepted words with nonzero syndrome
- err_clr  in  1  synchronous clear of err_count

## Operation
- Syndrome s = p0 + 2·p1 + 4·p2 + 8·p3, parity equations as in column_hamming_dec. Data bit k is inverted when (s−1) mod 16 equals 2,4,5,6,8,9 for k = 0..5. out_syn_err = (s != 0).
- Two states: EMPTY (out_valid=0), FULL (out_valid=1).
- can_accept = EMPTY, or FULL & out_ready. A requester can be granted only when can_accept is high and req is nonzero.
- Arbitration: rotating pointer ptr (0..NREQ−1). Grant goes to the first i with req[i]=1, searching ptr, ptr+1, …, wrapping mod NREQ. After a grant to i, ptr ← (i+1) mod NREQ. ptr is unchanged when there is no grant.
- On a grant: gnt[i]=1 for that cycle. At the edge, out_col/out_src/out_syn_err load decoded data from word i and the state becomes FULL.
- FULL & out_ready with no grant → EMPTY. FULL & out_ready with a grant → stays FULL with the new data (back-to-back, one word per cycle).
- FULL & !out_ready: gnt=0, and outputs stay stable until accepted.
- err_count increments on each grant with s != 0 and saturates at 2^CNT_W−1. err_clr has priority: when it coincides with an increment, the result is 0.
- Decode is combinational on the muxed word. Only the output register, ptr, and counter are sequential.
- Requester indices ≥ NREQ never appear. Upper bits of out_src are 0 when NREQ < 8.

## Timing
- Reset (asynchronous, any time including mid-transfer): out_valid=0, out_col=0, out_src=0, out_syn_err=0, err_count=0, ptr=0, gnt=0. The pending output is discarded.
- gnt is combinational from req, ptr, state, and out_ready, and is asserted in cycle N. out_valid rises in cycle N+1 with the data. Latency is 1 clock.
- Requester must drop or update req at the edge that ends its gnt cycle. A req still high in the next cycle is treated as a new request.
- Throughput is 1 word/clock when out_ready stays high.
- No combinational path from out_ready to out_valid/out_col.

## Test plan
- Reset then idle: all outputs 0. Assert req[2] with word 10'h315 → gnt=4'b0100 for 1 cycle. Next cycle: out_valid=1, out_col=6'h15, out_src=2, out_syn_err=0, err_count=0.
- Single-bit correction: word 10'h305 (bit 4 flipped) → out_col=6'h15, out_syn_err=1, err_count=1. Word 10'h001 → out_col=0, out_syn_err=1. Parity-only 10'h040 → out_col=0, out_syn_err=1.
- Fairness: req=4'b1111 held with out_ready=1 → grants 0,1,2,3,0 on consecutive cycles, and out_src follows one cycle later.
- Backpressure: out_ready=0 while FULL with req[1]=1 → gnt stays 0 and out_col stays stable. Raise out_ready → gnt[1] in the same cycle, and new data the next cycle with no bubble.
- Counter: CNT_W=2, feed 5 erroneous words → err_count saturates at 3. Assert err_clr together with a 6th erroneous grant → err_count=0.
- Async reset asserted while FULL and req pending → out_valid=0 immediately. After release, arbitration restarts at ptr=0.
